// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges results from the ALU, MUL and DIV units onto a single
// common data bus toward the ROB. Each source feeds its own DEPTH-entry FIFO;
// a round-robin arbiter pops at most one head per cycle and registers it onto
// the CDB outputs one edge later.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   ROB_Flush                      discard all buffered results
//   {alu,mul,div}_valid/value/PC   source result handshake and payload
//   {alu,mul,div}_ready            FIFO can accept a result this cycle
//   cdb_done/cdb_value/cdb_PC      registered completion strobe and payload
//   cdb_src                        winner: 0 = ALU, 1 = MUL, 2 = DIV
//   conflict_count                 only with CDB_CONFLICT_CNT_EN defined:
//                                  saturating count of cycles where two or
//                                  more FIFOs were non-empty
//
// Optional feature macro: CDB_CONFLICT_CNT_EN

package cdb_arbiter_pkg;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SRC = 3;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] pc;
  } cdb_entry_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ROB_Flush,
  input  logic        alu_valid,
  input  logic [31:0] alu_value,
  input  logic [31:0] alu_PC,
  input  logic        mul_valid,
  input  logic [31:0] mul_value,
  input  logic [31:0] mul_PC,
  input  logic        div_valid,
  input  logic [31:0] div_value,
  input  logic [31:0] div_PC,
  output logic        alu_ready,
  output logic        mul_ready,
  output logic        div_ready,
  output logic        cdb_done,
  output logic [31:0] cdb_value,
  output logic [31:0] cdb_PC,
  output logic [1:0]  cdb_src
`ifdef CDB_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [NUM_SRC-1:0] in_valid;
  cdb_entry_t         in_entry [NUM_SRC];

  logic [NUM_SRC-1:0] ready_c;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] nonempty;

  logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
  logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
  logic [CNT_W-1:0]   count  [NUM_SRC];
  cdb_entry_t         mem    [NUM_SRC][DEPTH];
  cdb_entry_t         head   [NUM_SRC];

  logic               grant_valid;
  logic [1:0]         grant_idx;
  logic [1:0]         rr_ptr;
  logic [1:0]         rr_next;
  cdb_entry_t         grant_entry;

  // Gather the three source interfaces into indexable form.
  assign in_valid = {div_valid, mul_valid, alu_valid};

  always_comb begin
    in_entry[0].value = alu_value;
    in_entry[0].pc    = alu_PC;
    in_entry[1].value = mul_value;
    in_entry[1].pc    = mul_PC;
    in_entry[2].value = div_value;
    in_entry[2].pc    = div_PC;
  end

  // Ready depends only on the current count: a full FIFO never accepts,
  // even when it is being popped in the same cycle.
  always_comb begin
    ready_c  = '0;
    push     = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready_c[i]  = !rst && !ROB_Flush && (count[i] < CNT_W'(DEPTH));
      push[i]     = in_valid[i] && ready_c[i];
      nonempty[i] = (count[i] != '0);
      head[i]     = mem[i][rd_ptr[i]];
    end
  end

  assign alu_ready = ready_c[0];
  assign mul_ready = ready_c[1];
  assign div_ready = ready_c[2];

  // Round-robin scan starting at rr_ptr and wrapping modulo 3.
  always_comb begin
    grant_valid = |nonempty;
    grant_idx   = 2'd0;
    case (rr_ptr)
      2'd1: begin
        if      (nonempty[1]) grant_idx = 2'd1;
        else if (nonempty[2]) grant_idx = 2'd2;
        else                  grant_idx = 2'd0;
      end
      2'd2: begin
        if      (nonempty[2]) grant_idx = 2'd2;
        else if (nonempty[0]) grant_idx = 2'd0;
        else                  grant_idx = 2'd1;
      end
      default: begin
        if      (nonempty[0]) grant_idx = 2'd0;
        else if (nonempty[1]) grant_idx = 2'd1;
        else                  grant_idx = 2'd2;
      end
    endcase

    rr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;

    // Flush and reset suppress the pop so no entry is consumed silently.
    pop = '0;
    if (grant_valid && !rst && !ROB_Flush) begin
      pop = NUM_SRC'(1) << grant_idx;
    end

    case (grant_idx)
      2'd1:    grant_entry = head[1];
      2'd2:    grant_entry = head[2];
      default: grant_entry = head[0];
    endcase
  end

  // FIFO bookkeeping, arbiter pointer and registered CDB outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr    <= 2'd0;
      cdb_done  <= 1'b0;
      cdb_value <= '0;
      cdb_PC    <= '0;
      cdb_src   <= 2'd0;
    end else if (ROB_Flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr   <= 2'd0;
      cdb_done <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      if (grant_valid) begin
        cdb_done  <= 1'b1;
        cdb_value <= grant_entry.value;
        cdb_PC    <= grant_entry.pc;
        cdb_src   <= grant_idx;
        rr_ptr    <= rr_next;
      end else begin
        cdb_done  <= 1'b0;
      end
    end
  end

  // Storage is not reset; pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

`ifdef CDB_CONFLICT_CNT_EN
  logic multi_c;

  assign multi_c = (nonempty[0] && nonempty[1]) ||
                   (nonempty[0] && nonempty[2]) ||
                   (nonempty[1] && nonempty[2]);

  // Saturating count of cycles with competing non-empty FIFOs.
  always_ff @(posedge clk) begin
    if (rst || ROB_Flush) begin
      conflict_count <= 16'h0000;
    end else if (multi_c && (conflict_count != 16'hFFFF)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed steps with a per-source
// scoreboard checked by a CDB monitor.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ROB_Flush;
  logic        alu_valid, mul_valid, div_valid;
  logic [31:0] alu_value, mul_value, div_value;
  logic [31:0] alu_PC, mul_PC, div_PC;
  logic        alu_ready, mul_ready, div_ready;
  logic        cdb_done;
  logic [31:0] cdb_value;
  logic [31:0] cdb_PC;
  logic [1:0]  cdb_src;
`ifdef CDB_CONFLICT_CNT_EN
  logic [15:0] conflict_count;
`endif

  int tests = 0;
  int fails = 0;
  int n_done [3] = '{0, 0, 0};

  logic [63:0] q_alu [$];
  logic [63:0] q_mul [$];
  logic [63:0] q_div [$];
  logic [63:0] mon_exp;
  bit          mon_have;

  cdb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ROB_Flush(ROB_Flush),
    .alu_valid(alu_valid), .alu_value(alu_value), .alu_PC(alu_PC),
    .mul_valid(mul_valid), .mul_value(mul_value), .mul_PC(mul_PC),
    .div_valid(div_valid), .div_value(div_value), .div_PC(div_PC),
    .alu_ready(alu_ready), .mul_ready(mul_ready), .div_ready(div_ready),
    .cdb_done(cdb_done), .cdb_value(cdb_value), .cdb_PC(cdb_PC),
    .cdb_src(cdb_src)
`ifdef CDB_CONFLICT_CNT_EN
    , .conflict_count(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_src(input int s, input logic v, input logic [31:0] pc, input logic [31:0] val);
    case (s)
      0: begin alu_valid = v; alu_PC = pc; alu_value = val; end
      1: begin mul_valid = v; mul_PC = pc; mul_value = val; end
      default: begin div_valid = v; div_PC = pc; div_value = val; end
    endcase
  endtask

  function automatic logic get_ready(input int s);
    case (s)
      0: return alu_ready;
      1: return mul_ready;
      default: return div_ready;
    endcase
  endfunction

  task automatic expect_push(input int s, input logic [31:0] pc, input logic [31:0] val);
    case (s)
      0: q_alu.push_back({pc, val});
      1: q_mul.push_back({pc, val});
      default: q_div.push_back({pc, val});
    endcase
  endtask

  task automatic clear_queues();
    q_alu.delete();
    q_mul.delete();
    q_div.delete();
  endtask

  function automatic int pending();
    return q_alu.size() + q_mul.size() + q_div.size();
  endfunction

  function automatic int total_done();
    return n_done[0] + n_done[1] + n_done[2];
  endfunction

  task automatic do_flush();
    ROB_Flush = 1'b1;
    tick();
    clear_queues();
    ROB_Flush = 1'b0;
  endtask

  // Valid/ready sources: each enabled source offers n_items results, holding
  // an item until ready is seen. Records the first cycle MUL was refused.
  task automatic stream(input logic [2:0] en, input int n_items, input logic [31:0] base_pc,
                        input int cycles, output int mul_block_at);
    int sent [3];
    sent = '{0, 0, 0};
    mul_block_at = -1;
    for (int c = 0; c < cycles; c++) begin
      for (int s = 0; s < 3; s++) begin
        set_src(s, en[s] && (sent[s] < n_items),
                base_pc + 32'(s * 64) + 32'(4 * sent[s]),
                32'hC0DE_0000 | 32'(s << 12) | 32'(sent[s]));
      end
      #1;
      for (int s = 0; s < 3; s++) begin
        if (en[s] && (sent[s] < n_items)) begin
          if (get_ready(s)) begin
            expect_push(s, base_pc + 32'(s * 64) + 32'(4 * sent[s]),
                        32'hC0DE_0000 | 32'(s << 12) | 32'(sent[s]));
            sent[s]++;
          end else if (s == 1 && mul_block_at < 0) begin
            mul_block_at = c;
          end
        end
      end
      tick();
    end
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && pending() != 0; c++) tick();
    tick();
    check(tag, 64'(pending()), 64'(0));
  endtask

  // CDB monitor: every completion must match the oldest pending entry of its source.
  always @(negedge clk) begin
    if (!rst && cdb_done) begin
      mon_have = 1'b0;
      case (cdb_src)
        2'd0: if (q_alu.size() != 0) begin mon_exp = q_alu.pop_front(); mon_have = 1'b1; end
        2'd1: if (q_mul.size() != 0) begin mon_exp = q_mul.pop_front(); mon_have = 1'b1; end
        2'd2: if (q_div.size() != 0) begin mon_exp = q_div.pop_front(); mon_have = 1'b1; end
        default: mon_have = 1'b0;
      endcase
      if (cdb_src != 2'd3) n_done[cdb_src]++;
      if (mon_have) begin
        check("cdb_entry", {cdb_PC, cdb_value}, mon_exp);
      end else begin
        tests++;
        fails++;
        $error("FAIL cdb_unexpected: got src %0d pc %0h expected no completion", cdb_src, cdb_PC);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk;
    int snap;
    rst = 1'b1;
    ROB_Flush = 1'b0;
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 32'h0, 32'h0);

    // Reset state.
    tick();
    tick();
    check("rst_done",  64'(cdb_done),  64'(0));
    check("rst_value", 64'(cdb_value), 64'(0));
    check("rst_pc",    64'(cdb_PC),    64'(0));
    check("rst_src",   64'(cdb_src),   64'(0));
    check("rst_ready", 64'({div_ready, mul_ready, alu_ready}), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'({div_ready, mul_ready, alu_ready}), 64'(3'b111));

    // Single push: result appears one edge after the push edge only.
    set_src(0, 1'b1, 32'h0000_0010, 32'h0000_00AA);
    expect_push(0, 32'h0000_0010, 32'h0000_00AA);
    tick();
    set_src(0, 1'b0, 32'h0, 32'h0);
    check("single_k_done", 64'(cdb_done), 64'(0));
    tick();
    check("single_done",  64'(cdb_done),  64'(1));
    check("single_value", 64'(cdb_value), 64'(32'hAA));
    check("single_pc",    64'(cdb_PC),    64'(32'h10));
    check("single_src",   64'(cdb_src),   64'(0));
    tick();
    check("single_after", 64'(cdb_done), 64'(0));

    // Simultaneous push from all three sources with rr_ptr at 0.
    do_flush();
    set_src(0, 1'b1, 32'h20, 32'h1111_0020);
    set_src(1, 1'b1, 32'h24, 32'h2222_0024);
    set_src(2, 1'b1, 32'h28, 32'h3333_0028);
    expect_push(0, 32'h20, 32'h1111_0020);
    expect_push(1, 32'h24, 32'h2222_0024);
    expect_push(2, 32'h28, 32'h3333_0028);
    tick();
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 32'h0, 32'h0);
    check("rr_first_idle", 64'(cdb_done), 64'(0));
    tick();
    check("rr_pc0", 64'({cdb_done, cdb_src, cdb_PC}), 64'({1'b1, 2'd0, 32'h20}));
    tick();
    check("rr_pc1", 64'({cdb_done, cdb_src, cdb_PC}), 64'({1'b1, 2'd1, 32'h24}));
    tick();
    check("rr_pc2", 64'({cdb_done, cdb_src, cdb_PC}), 64'({1'b1, 2'd2, 32'h28}));
    tick();
    check("rr_end", 64'(cdb_done), 64'(0));

    // MUL backpressure while ALU competes for every grant.
    do_flush();
    stream(3'b011, 10, 32'h200, 16, blk);
    check("mul_full_cycle", 64'(blk), 64'(6));
    drain("mul_drain", 40);

    // Wrap DIV pointers with 10 entries.
    snap = n_done[2];
    stream(3'b100, 10, 32'h100 - 32'h80, 14, blk);
    drain("div_drain", 20);
    check("div_count", 64'(n_done[2] - snap), 64'(10));

    // Flush with entries buffered in every FIFO.
    stream(3'b111, 3, 32'h400, 3, blk);
    check("pre_flush_pending", 64'(pending() > 3), 64'(1));
    ROB_Flush = 1'b1;
    tick();
    clear_queues();
    ROB_Flush = 1'b0;
    #1;
    check("flush_done",  64'(cdb_done), 64'(0));
    check("flush_ready", 64'({div_ready, mul_ready, alu_ready}), 64'(3'b111));
    snap = total_done();
    for (int c = 0; c < 6; c++) tick();
    check("flush_no_stale", 64'(total_done() - snap), 64'(0));

`ifdef CDB_CONFLICT_CNT_EN
    // Three contended cycles between ALU and MUL.
    check("conf_zero", 64'(conflict_count), 64'(0));
    stream(3'b011, 2, 32'h600, 2, blk);
    drain("conf_drain", 10);
    check("conf_three", 64'(conflict_count), 64'(3));
`endif

    // Reset mid-operation discards buffered entries.
    stream(3'b111, 3, 32'h800, 3, blk);
    rst = 1'b1;
    tick();
    clear_queues();
    check("mid_rst_out", 64'({cdb_done, cdb_src, cdb_PC}), 64'(0));
    check("mid_rst_val", 64'(cdb_value), 64'(0));
    check("mid_rst_ready", 64'({div_ready, mul_ready, alu_ready}), 64'(0));
`ifdef CDB_CONFLICT_CNT_EN
    check("conf_rst", 64'(conflict_count), 64'(0));
`endif
    rst = 1'b0;
    #1;
    check("mid_rst_release", 64'({div_ready, mul_ready, alu_ready}), 64'(3'b111));
    snap = total_done();
    for (int c = 0; c < 6; c++) tick();
    check("rst_no_stale", 64'(total_done() - snap), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
